// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//   Sequencing controller and two-port round-robin arbiter in front of the
//   combinational 4-bit ALU. Each requester hands over (a, b, op) with a
//   valid/ready handshake. The winner's operands are registered onto the ALU
//   and held for SETTLE cycles. The result and invalid flag are then captured
//   and returned with a one-cycle done pulse. The last completed result is
//   also kept for the 7-segment driver.
//
// Ports
//   clk_i, rst_n_i              clock (rising edge), async active-low reset
//   reqN_valid_i / reqN_ready_o handshake for requester N (ready is combinational)
//   reqN_a_i, reqN_b_i, reqN_op_i  payload, sampled only at the accept edge
//   reqN_done_o                 one-cycle pulse when reqN_result_o is fresh
//   reqN_result_o/_invalid_o    last result and flag returned to requester N
//   alu_a_o, alu_b_o, alu_op_o  registered operands to the ALU
//   alu_result_i, alu_invalid_i ALU outputs
//   disp_value_o                last completed result of either requester
//   busy_o                      controller is not idle
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int DATA_W = 4,
   parameter int OP_W   = 4,
   parameter int SETTLE = 1        // 1..15
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic [OP_W-1:0]   req0_op_i,
   output logic              req0_done_o,
   output logic [DATA_W-1:0] req0_result_o,
   output logic              req0_invalid_o,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   input  logic [OP_W-1:0]   req1_op_i,
   output logic              req1_done_o,
   output logic [DATA_W-1:0] req1_result_o,
   output logic              req1_invalid_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [OP_W-1:0]   alu_op_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_invalid_i,
   output logic [DATA_W-1:0] disp_value_o,
   output logic              busy_o
);

   // The capture step is the single edge leaving ISSUE when the counter hits
   // zero, so it needs no state of its own. IDLE + SETTLE x ISSUE + DONE gives
   // one operation every SETTLE+2 cycles.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       grant;       // requester currently being served
   logic       last_grant;  // requester served most recently
   logic       sel;         // requester that would win this cycle
   logic       any_valid;

   // Round-robin choice: on contention the requester not served last wins.
   always_comb begin
      sel       = 1'b0;
      any_valid = req0_valid_i | req1_valid_i;
      if (req0_valid_i && req1_valid_i)
         sel = ~last_grant;
      else if (req1_valid_i)
         sel = 1'b1;
   end

   assign req0_ready_o = (state == IDLE) && req0_valid_i && !sel;
   assign req1_ready_o = (state == IDLE) && req1_valid_i &&  sel;
   assign busy_o       = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= IDLE;
         cnt            <= '0;
         grant          <= 1'b0;
         last_grant     <= 1'b1;   // requester 0 wins the first contention
         alu_a_o        <= '0;
         alu_b_o        <= '0;
         alu_op_o       <= '0;
         req0_done_o    <= 1'b0;
         req0_result_o  <= '0;
         req0_invalid_o <= 1'b0;
         req1_done_o    <= 1'b0;
         req1_result_o  <= '0;
         req1_invalid_o <= 1'b0;
         disp_value_o   <= '0;
      end else begin
         // done is a pulse: only the capture edge raises it
         req0_done_o <= 1'b0;
         req1_done_o <= 1'b0;
         case (state)
            IDLE: begin
               // any_valid implies the selected requester's ready is high
               if (any_valid) begin
                  alu_a_o  <= sel ? req1_a_i  : req0_a_i;
                  alu_b_o  <= sel ? req1_b_i  : req0_b_i;
                  alu_op_o <= sel ? req1_op_i : req0_op_i;
                  grant    <= sel;
                  cnt      <= CNT_INIT;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (cnt == 4'd0) begin
                  if (grant) begin
                     req1_result_o  <= alu_result_i;
                     req1_invalid_o <= alu_invalid_i;
                     req1_done_o    <= 1'b1;
                  end else begin
                     req0_result_o  <= alu_result_i;
                     req0_invalid_o <= alu_invalid_i;
                     req0_done_o    <= 1'b1;
                  end
                  disp_value_o <= alu_result_i;
                  last_grant   <= grant;
                  state        <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
